snow64_memory_bus_guard: RTL and testbench
==========================================

// Module: snow64_memory_bus_guard
// PURPOSE
//  Single-outstanding arbiter between the memory-access read FIFO and write FIFO
//  (upstream) and the external 256-bit memory port (downstream). Grants one FIFO
//  command at a time (round-robin on contention), pulses cmd_accepted, drives the
//  memory handshake, returns read data / write completion as a one-cycle valid.
//  Sticky timeout flag when memory fails to respond.
// PARAMETERS
//  ADDR_WIDTH     64    CPU address width
//  DATA_WIDTH     256   LAR-file line width
//  TIMEOUT_CYCLES 1024  max WAIT_DATA cycles before forced completion (>=2)
// PORTS
//  clk              in   1     single clock, all logic posedge
//  rst_n            in   1     reset: synchronous, active-low
//  rd_req           in   1     read FIFO request, held until rd_cmd_accepted
//  rd_addr          in   ADDR  read address
//  rd_cmd_accepted  out  1     1-cycle pulse: read command granted
//  rd_valid         out  1     1-cycle pulse: rd_data valid
//  rd_data          out  DATA  read line, held until next read completion
//  wr_req           in   1     write FIFO request, held until wr_cmd_accepted
//  wr_addr          in   ADDR  write address
//  wr_data          in   DATA  write line
//  wr_cmd_accepted  out  1     1-cycle pulse: write command granted
//  wr_valid         out  1     1-cycle pulse: write completed
//  mem_req          out  1     memory command, held until mem_ack
//  mem_we           out  1     1 = write, 0 = read
//  mem_addr         out  ADDR  memory address
//  mem_wdata        out  DATA  memory write data
//  mem_ack          in   1     memory accepted command (sampled only while mem_req=1)
//  mem_valid        in   1     read data / write done (sampled only in WAIT_DATA)
//  mem_rdata        in   DATA  memory read data
//  timeout_err      out  1     sticky: a transaction timed out
// BEHAVIOUR
//  Reset (rst_n=0 at edge): every output 0, state IDLE, last_grant=WRITE, timer 0,
//   timeout_err 0. Reset mid-transaction abandons it; late mem_ack/mem_valid ignored.
//  States IDLE -> ISSUE -> WAIT_DATA -> IDLE. All outputs registered.
//  IDLE: rd_req/wr_req sampled only here. Both high: grant side != last_grant.
//   On grant at edge N: at N+1 x_cmd_accepted=1 (one cycle), mem_req=1, mem_we,
//   mem_addr, mem_wdata (wr_data, else unchanged) latched; last_grant updated; -> ISSUE.
//  ISSUE: mem_req held with stable addr/data until mem_ack=1; next cycle mem_req=0,
//   -> WAIT_DATA, timer cleared. mem_ack && mem_valid same cycle: complete directly
//   (skip WAIT_DATA).
//  WAIT_DATA: mem_valid=1 at edge M -> at M+1 rd_valid=1 with rd_data=mem_rdata (read)
//   or wr_valid=1 (write), one cycle, -> IDLE. New grant possible at M+1 edge.
//  Timer: increments each WAIT_DATA cycle; at TIMEOUT_CYCLES-1 without mem_valid:
//   complete as above (rd_data=0 for reads), set timeout_err, -> IDLE.
//   timeout_err clears only on reset. Timer saturating, width $clog2(TIMEOUT_CYCLES).
//  Upstream FIFO drops req one cycle after cmd_accepted. Guard never re-grants
//   before IDLE, so a lingering req is harmless. Minimum turnaround: 3 cycles.
//  Never both cmd_accepted high; never both valid high; valid never in same cycle
//   as that side's cmd_accepted.
// STRUCTURE
//  PkgSnow64MemoryBusGuard: state enum (GrdStIdle/Issue/WaitData), grant enum
//   (GrdGrantRead/Write), port structs matching read/write FIFO partial ports.
//  Widths from existing SNOW64 CPU_ADDR / LAR_FILE_DATA defines.
//  Sub-module: snow64_rr_arbiter2 (2-way round-robin, last_grant register, enable).
// TESTING
//  Reads only: rd_req addr 0x40; mem_ack 1 cycle later, mem_valid 3 cycles after that,
//   rdata 0xAA..AA. Expect rd_cmd_accepted 1 pulse, rd_valid 1 pulse, rd_data 0xAA..AA.
//  Writes only: wr_req addr 0x80, data 0x55..55. Expect mem_we=1, mem_wdata 0x55..55,
//   wr_valid pulse after mem_valid.
//  Contention: rd_req and wr_req same cycle, out of reset. Expect read granted first,
//   then write. Repeat with both held: grants alternate R,W,R,W.
//  Timeout, TIMEOUT_CYCLES=8: ack but never valid. Expect rd_valid exactly 8 cycles
//   into WAIT_DATA, rd_data=0, timeout_err=1 persisting.
//  Reset during WAIT_DATA, then mem_valid pulse: all outputs 0, no rd_valid,
//   next request serviced normally.
//  Ack+valid same cycle: read completes, rd_valid on next edge.

Source files
------------

// File: rtl/snow64_memory_bus_guard_pkg.sv
// Shared types for the SNOW64 memory bus guard: FSM states, grant side,
// FIFO-facing port bundles and the round-robin pick rule.
package snow64_memory_bus_guard_pkg;

    localparam int CPU_ADDR_WIDTH      = 64;
    localparam int LAR_FILE_DATA_WIDTH = 256;

    typedef enum logic [1:0] {
        GRD_ST_IDLE,
        GRD_ST_ISSUE,
        GRD_ST_WAIT_DATA
    } grd_state_t;

    typedef enum logic {
        GRD_GRANT_READ,
        GRD_GRANT_WRITE
    } grd_grant_t;

    // Partial views of the read / write request FIFO ports.
    typedef struct packed {
        logic                      req;
        logic [CPU_ADDR_WIDTH-1:0] addr;
    } rd_fifo_port_t;

    typedef struct packed {
        logic                           req;
        logic [CPU_ADDR_WIDTH-1:0]      addr;
        logic [LAR_FILE_DATA_WIDTH-1:0] data;
    } wr_fifo_port_t;

    // On contention the side that did not win last time goes next.
    function automatic grd_grant_t rr_pick(input logic rd, input logic wr,
                                           input grd_grant_t last);
        if (rd && wr) begin
            return (last == GRD_GRANT_WRITE) ? GRD_GRANT_READ : GRD_GRANT_WRITE;
        end
        return wr ? GRD_GRANT_WRITE : GRD_GRANT_READ;
    endfunction

endpackage

// File: rtl/snow64_rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant memory; the
// history only advances when a grant is actually taken (enable high).
module snow64_rr_arbiter2
    import snow64_memory_bus_guard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req_rd,
    input  logic       req_wr,
    output logic       grant_valid,
    output grd_grant_t grant
);

    grd_grant_t last_grant_reg;

    always_comb begin
        grant_valid = enable && (req_rd || req_wr);
        grant       = rr_pick(req_rd, req_wr, last_grant_reg);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_reg <= GRD_GRANT_WRITE;
        end else if (grant_valid) begin
            last_grant_reg <= grant;
        end
    end

endmodule

// File: rtl/snow64_memory_bus_guard.sv
// Single-outstanding guard between the read/write request FIFOs and the wide
// memory port: one command at a time, one-cycle completion pulses, sticky timeout.
module snow64_memory_bus_guard
    import snow64_memory_bus_guard_pkg::*;
#(
    parameter int ADDR_WIDTH     = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH     = LAR_FILE_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_cmd_accepted,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_cmd_accepted,
    output logic                  wr_valid,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  timeout_err
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    grd_state_t             state_reg;
    logic [TIMER_WIDTH-1:0] timer_reg;
    logic                   op_write_reg;

    logic                   grant_valid;
    grd_grant_t             grant;

    logic                   done_now;
    logic                   timed_out;
    logic [DATA_WIDTH-1:0]  done_data;

    snow64_rr_arbiter2 u_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (state_reg == GRD_ST_IDLE),
        .req_rd      (rd_req),
        .req_wr      (wr_req),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Completion detection. mem_req is always high in ISSUE, so mem_ack needs
    // no extra qualification there; mem_valid only counts in ISSUE (with the
    // ack) or WAIT_DATA, so stray or late pulses are ignored everywhere else.
    always_comb begin
        done_now  = 1'b0;
        timed_out = 1'b0;
        done_data = mem_rdata;
        case (state_reg)
            GRD_ST_ISSUE: begin
                done_now = mem_ack && mem_valid;
            end
            GRD_ST_WAIT_DATA: begin
                timed_out = !mem_valid && (timer_reg == TIMER_LAST);
                done_now  = mem_valid || timed_out;
            end
            default: begin
                done_now = 1'b0;
            end
        endcase
        if (timed_out) begin
            done_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= GRD_ST_IDLE;
            timer_reg       <= '0;
            op_write_reg    <= 1'b0;
            rd_cmd_accepted <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            wr_cmd_accepted <= 1'b0;
            wr_valid        <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            rd_cmd_accepted <= 1'b0;
            wr_cmd_accepted <= 1'b0;
            rd_valid        <= 1'b0;
            wr_valid        <= 1'b0;

            case (state_reg)
                GRD_ST_IDLE: begin
                    if (grant_valid) begin
                        mem_req   <= 1'b1;
                        state_reg <= GRD_ST_ISSUE;
                        if (grant == GRD_GRANT_WRITE) begin
                            wr_cmd_accepted <= 1'b1;
                            mem_we          <= 1'b1;
                            op_write_reg    <= 1'b1;
                            mem_addr        <= wr_addr;
                            mem_wdata       <= wr_data;
                        end else begin
                            rd_cmd_accepted <= 1'b1;
                            mem_we          <= 1'b0;
                            op_write_reg    <= 1'b0;
                            mem_addr        <= rd_addr;
                        end
                    end
                end

                GRD_ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        timer_reg <= '0;
                        if (!mem_valid) begin
                            state_reg <= GRD_ST_WAIT_DATA;
                        end
                    end
                end

                GRD_ST_WAIT_DATA: begin
                    if (!done_now && timer_reg != TIMER_LAST) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= GRD_ST_IDLE;
                end
            endcase

            if (done_now) begin
                state_reg <= GRD_ST_IDLE;
                if (op_write_reg) begin
                    wr_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b1;
                    rd_data  <= done_data;
                end
                if (timed_out) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snow64_memory_bus_guard.sv
// Scoreboard bench for the memory bus guard: request FIFO drivers, a randomized
// memory responder with its own backing store, and an independent completion monitor.
`timescale 1ns/1ps
module tb_snow64_memory_bus_guard;

    localparam int AW = 64;
    localparam int DW = 256;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_cmd_accepted, rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_cmd_accepted, wr_valid;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic          resp_valid = 1'b0;
    logic          stray_valid = 1'b0;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata = '0;
    logic          timeout_err;

    assign mem_valid = resp_valid | stray_valid;

    snow64_memory_bus_guard #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_cmd_accepted (rd_cmd_accepted),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_cmd_accepted (wr_cmd_accepted),
        .wr_valid        (wr_valid),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_valid       (mem_valid),
        .mem_rdata       (mem_rdata),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        bit            is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        bit            timeout;
        int            due;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int outstanding = 0;
    int resp_mode = 0;   // 0 random, 1 fixed latencies, 2 never valid, 3 ack then hang
    bit hang_seen = 1'b0;

    logic [AW-1:0] rd_q[$];
    cmd_t          wr_q[$];
    cmd_t          cmd_q[$];
    exp_t          sb_q[$];
    logic [DW-1:0] mem_model[logic [AW-1:0]];

    // reference state
    bit            last_w = 1'b1;
    logic [DW-1:0] exp_wdata = '0;
    logic [DW-1:0] exp_rd_data = '0;
    bit            exp_terr = 1'b0;

    bit            p_rd, p_wr;
    logic [AW-1:0] p_rd_addr, p_wr_addr;
    logic [DW-1:0] p_wr_data;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        p_rd      <= rd_req;
        p_wr      <= wr_req;
        p_rd_addr <= rd_addr;
        p_wr_addr <= wr_addr;
        p_wr_data <= wr_data;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {4{a}} ^ {8{32'hC3A5_0F1E}};
    endfunction

    // read FIFO: present head, drop req once the grant pulse is seen
    initial begin : rd_fifo
        forever begin
            @(negedge clk); #1;
            if (rd_req && rd_cmd_accepted) begin
                rd_req = 1'b0;
            end else if (!rd_req && rd_q.size() > 0) begin
                rd_addr = rd_q.pop_front();
                rd_req  = 1'b1;
            end
        end
    end

    initial begin : wr_fifo
        cmd_t w;
        forever begin
            @(negedge clk); #1;
            if (wr_req && wr_cmd_accepted) begin
                wr_req = 1'b0;
            end else if (!wr_req && wr_q.size() > 0) begin
                w       = wr_q.pop_front();
                wr_addr = w.addr;
                wr_data = w.wdata;
                wr_req  = 1'b1;
            end
        end
    end

    // memory responder: decides latencies and pushes the expected completion
    initial begin : responder
        cmd_t          c;
        exp_t          e;
        int            ack_dly, val_dly;
        bit            same;
        forever begin
            @(negedge clk); #1;
            if (rst_n && mem_req && !mem_ack) begin
                ack_dly = (resp_mode == 1) ? 1 : int'($urandom_range(0, 2));
                repeat (ack_dly) begin @(negedge clk); #1; end
                if (cmd_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL mem_req_without_grant: got mem_req=1 required no command");
                    continue;
                end
                c = cmd_q.pop_front();
                chk("mem_cmd_stable", {mem_we, mem_addr}, {c.is_write, c.addr});
                chk("mem_wdata_stable", mem_wdata, c.wdata);
                mem_ack   = 1'b1;
                mem_rdata = {8{$urandom()}};
                same      = (resp_mode == 0) && ($urandom_range(0, 3) == 0);
                e.is_write = c.is_write;
                e.addr     = c.addr;
                e.timeout  = 1'b0;
                e.rdata    = c.is_write ? '0 : mem_lookup(c.addr);
                if (same) begin
                    mem_rdata  = e.rdata;
                    resp_valid = 1'b1;
                    e.due      = cyc + 1;
                    sb_q.push_back(e);
                    if (c.is_write) mem_model[c.addr] = c.wdata;
                    @(negedge clk); #1;
                    mem_ack = 1'b0; resp_valid = 1'b0;
                end else begin
                    if (resp_mode == 2) begin
                        e.rdata   = '0;
                        e.timeout = 1'b1;
                        e.due     = cyc + 1 + TO;
                        sb_q.push_back(e);
                    end
                    @(negedge clk); #1;
                    mem_ack = 1'b0;
                    chk("mem_req_drop", {255'b0, mem_req}, '0);
                    if (resp_mode == 3) hang_seen = 1'b1;
                    if (resp_mode <= 1) begin
                        val_dly = (resp_mode == 1) ? 3 : int'($urandom_range(1, 5));
                        repeat (val_dly - 1) begin @(negedge clk); #1; end
                        mem_rdata  = e.rdata;
                        resp_valid = 1'b1;
                        e.due      = cyc + 1;
                        sb_q.push_back(e);
                        if (c.is_write) mem_model[c.addr] = c.wdata;
                        @(negedge clk); #1;
                        resp_valid = 1'b0;
                        mem_rdata  = {8{$urandom()}};
                    end
                end
            end
        end
    end

    // monitor: grant order, command contents, completions against the scoreboard
    initial begin : monitor
        exp_t          e;
        bit            want_w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_ctl", {249'b0, rd_cmd_accepted, rd_valid, wr_cmd_accepted,
                                  wr_valid, mem_req, mem_we, timeout_err}, '0);
                chk("reset_rd_data", rd_data, '0);
                chk("reset_mem_addr", {192'b0, mem_addr}, '0);
                chk("reset_mem_wdata", mem_wdata, '0);
                last_w = 1'b1; exp_wdata = '0; exp_rd_data = '0; exp_terr = 1'b0;
                outstanding = 0;
                sb_q.delete(); cmd_q.delete();
                continue;
            end
            if (rd_cmd_accepted || wr_cmd_accepted) begin
                want_w = (p_rd && p_wr) ? !last_w : p_wr;
                chk("grant_side", {254'b0, rd_cmd_accepted, wr_cmd_accepted},
                    (p_rd || p_wr) ? (want_w ? 256'd1 : 256'd2) : 256'd0);
                last_w = want_w;
                if (want_w) exp_wdata = p_wr_data;
                chk("grant_mem_cmd", {mem_req, mem_we, mem_addr},
                    {1'b1, want_w, want_w ? p_wr_addr : p_rd_addr});
                chk("grant_mem_wdata", mem_wdata, exp_wdata);
                cmd_q.push_back('{want_w, want_w ? p_wr_addr : p_rd_addr, exp_wdata});
                outstanding++;
            end
            if (rd_valid || wr_valid) begin
                chk("valid_exclusive", {253'b0, rd_valid & wr_valid, rd_valid & rd_cmd_accepted,
                                        wr_valid & wr_cmd_accepted}, '0);
                if (sb_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_valid: got rd_valid=%0b wr_valid=%0b required none",
                             rd_valid, wr_valid);
                end else begin
                    e = sb_q.pop_front();
                    chk("completion_side", {255'b0, wr_valid}, {255'b0, e.is_write});
                    chk("completion_cycle", DW'(cyc), DW'(e.due));
                    if (!e.is_write) exp_rd_data = e.rdata;
                    chk("rd_data", rd_data, exp_rd_data);
                    if (e.timeout) exp_terr = 1'b1;
                    chk("timeout_err", {255'b0, timeout_err}, {255'b0, exp_terr});
                    outstanding--;
                    $display("txn %s addr=%h cyc=%0d timeout=%0b data=%h", e.is_write ? "WR" : "RD",
                             e.addr, cyc, e.timeout, e.is_write ? mem_wdata : rd_data);
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || rd_req || wr_req || outstanding != 0 ||
                mem_ack || resp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            vectors++; miscompares++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t w;
        w.is_write = 1'b1; w.addr = a; w.wdata = d;
        wr_q.push_back(w);
    endtask

    initial begin : main
        int n;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // contention straight out of reset: read goes first
        @(posedge clk); #1;
        rd_q.push_back(64'h100);
        push_wr(64'h180, {8{32'hDEAD_BEEF}});
        wait_idle(200, "contention");

        // directed read / write with fixed latencies
        resp_mode = 1;
        mem_model[64'h40] = {32{8'hAA}};
        rd_q.push_back(64'h40);
        wait_idle(200, "dir_read");
        chk("dir_rd_data", rd_data, {32{8'hAA}});
        push_wr(64'h80, {32{8'h55}});
        wait_idle(200, "dir_write");
        chk("dir_mem_wdata", mem_wdata, {32{8'h55}});

        // both FIFOs held full: grants alternate
        resp_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rd_q.push_back(AW'(i) << 5);
            push_wr(AW'(i + 8) << 5, {8{$urandom()}});
        end
        wait_idle(1000, "alternate");

        // memory never answers: forced completion and sticky flag
        resp_mode = 2;
        rd_q.push_back(64'h40);
        wait_idle(200, "timeout");
        chk("timeout_rd_data", rd_data, '0);
        chk("timeout_err_set", {255'b0, timeout_err}, 256'd1);
        resp_mode = 0;
        push_wr(64'h20, {8{$urandom()}});
        wait_idle(200, "after_timeout");
        chk("timeout_err_sticky", {255'b0, timeout_err}, 256'd1);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) push_wr(AW'($urandom_range(0, 7)) << 5, {8{$urandom()}});
            else rd_q.push_back(AW'($urandom_range(0, 7)) << 5);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(5000, "random");

        // reset while waiting for data, then a late mem_valid
        hang_seen = 1'b0;
        resp_mode = 3;
        rd_q.push_back(64'h60);
        n = 0;
        while (!hang_seen && n < 100) begin @(negedge clk); n++; end
        if (!hang_seen) begin
            vectors++; miscompares++;
            $display("FAIL hang_ack: got no ack within 100 cycles, required ack");
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        stray_valid = 1'b1;
        mem_rdata   = {8{32'h1234_5678}};
        @(negedge clk); #1;
        stray_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_reset_rd_data", rd_data, '0);
        resp_mode = 0;
        rd_q.push_back(64'h40);
        wait_idle(200, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
